ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO registers, sitting in the EX stage directly downstream of the ID/EX pipeline register and consuming its registered operands and control. It executes MULT, MULTU, DIV and DIVU over multiple cycles and supplies MFHI/MFLO results to the EX result mux. While an operation is in progress it raises a stall to the hazard unit, which freezes PC, IF/ID and ID/EX.

---
 rtl/ex_muldiv_unit.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative multiply/divide unit with architectural HI/LO registers, placed in
// the EX stage right after the ID/EX pipeline register. It executes MULT,
// MULTU, DIV and DIVU over 32 iterations (one bit per cycle) and supplies
// MFHI/MFLO results to the EX result mux. While an operation is running it
// asks the hazard unit to freeze PC, IF/ID and ID/EX.
//
// Ports
//   clk          pipeline clock, all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   ID_EX_ALUOp  EX control from ID/EX; 2'b10 marks an R-type instruction
//   ID_EX_Funct  funct field of the EX instruction
//   OperandA     rs value after the forwarding mux
//   OperandB     rt value after the forwarding mux
//   Abort        exception/flush of the EX instruction; cancels any operation
//   MulDivStall  hold PC, IF/ID and ID/EX this cycle
//   MfSel        EX instruction is MFHI/MFLO; result mux should take MfResult
//   MfResult     HI for MFHI, LO for MFLO, otherwise 0
//   DivByZero    one-cycle pulse in the cycle after a divide by zero started
//   HI, LO       architectural HI/LO registers
//   o_dbg_state  current control state (0 idle, 1 busy, 2 done)
//
// Handshake: there is no valid/ready pair. The EX instruction is implicitly
// "valid" while it sits in ID/EX; MulDivStall is the only back-pressure and it
// keeps that instruction (and its operands) frozen until the DONE cycle, so
// the operands are only sampled once, in the start cycle.
// -----------------------------------------------------------------------------
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ID_EX_ALUOp,
    input  logic [5:0]  ID_EX_Funct,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    input  logic        Abort,
    output logic        MulDivStall,
    output logic        MfSel,
    output logic [31:0] MfResult,
    output logic        DivByZero,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] r_opnd;     // mult: multiplicand magnitude; div: divisor magnitude
    logic        r_is_div;
    logic        r_neg_lo;   // product / quotient must be negated at the end
    logic        r_neg_hi;   // remainder must be negated at the end (dividend negative)
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_div_zero;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic        w_rtype;
    logic        w_mult;
    logic        w_multu;
    logic        w_div;
    logic        w_divu;
    logic        w_mfhi;
    logic        w_mflo;
    logic        w_is_md;
    logic        w_is_div_op;
    logic        w_signed_op;
    logic        w_start;
    logic        w_div_zero;
    state_t      w_state_next;

    assign w_rtype     = (ID_EX_ALUOp == 2'b10);
    assign w_mult      = w_rtype && (ID_EX_Funct == FN_MULT);
    assign w_multu     = w_rtype && (ID_EX_Funct == FN_MULTU);
    assign w_div       = w_rtype && (ID_EX_Funct == FN_DIV);
    assign w_divu      = w_rtype && (ID_EX_Funct == FN_DIVU);
    assign w_mfhi      = w_rtype && (ID_EX_Funct == FN_MFHI);
    assign w_mflo      = w_rtype && (ID_EX_Funct == FN_MFLO);
    assign w_is_md     = w_mult || w_multu || w_div || w_divu;
    assign w_is_div_op = w_div || w_divu;
    assign w_signed_op = w_mult || w_div;

    // Gated by rst so that the combinational stall is also 0 while in reset.
    // DONE never starts: the instruction that just finished is still in EX.
    assign w_start    = rst && (r_state == ST_IDLE) && w_is_md && !Abort;
    assign w_div_zero = w_start && w_is_div_op && (OperandB == 32'd0);

    // -------------------------------------------------------------------------
    // Operand magnitudes. 0x80000000 negates to itself, which is the correct
    // unsigned magnitude, so no special case is needed.
    // -------------------------------------------------------------------------
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_abs_a = (w_signed_op && OperandA[31]) ? (32'd0 - OperandA) : OperandA;
    assign w_abs_b = (w_signed_op && OperandB[31]) ? (32'd0 - OperandB) : OperandB;

    // -------------------------------------------------------------------------
    // One iteration step
    // -------------------------------------------------------------------------
    // Shift-add multiply: add the multiplicand to the upper half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    // The carry out of the add becomes the new MSB.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Restoring divide: shift the next dividend bit into the remainder, try a
    // subtract, keep it if it did not go negative. The kept difference is
    // always below the divisor, so a 32-bit subtract yields it exactly.
    logic [32:0] w_div_shift;
    logic        w_div_ok;
    logic [31:0] w_div_rem;
    logic [63:0] w_div_next;

    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_rem   = w_div_ok ? (w_div_shift[31:0] - r_opnd) : w_div_shift[31:0];
    assign w_div_next  = {w_div_rem, r_acc[30:0], w_div_ok};

    logic [63:0] w_acc_next;
    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    // -------------------------------------------------------------------------
    // Final sign fix-up, applied to the value produced by the last iteration
    // -------------------------------------------------------------------------
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_prod = r_neg_lo ? (64'd0 - w_acc_next) : w_acc_next;
    assign w_quo  = r_neg_lo ? (32'd0 - w_acc_next[31:0])  : w_acc_next[31:0];
    assign w_rem  = r_neg_hi ? (32'd0 - w_acc_next[63:32]) : w_acc_next[63:32];

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = w_div_zero ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (Abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == 5'd31) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        MulDivStall = 1'b0;
        o_dbg_state = r_state;
        case (r_state)
            ST_IDLE: MulDivStall = w_start;
            ST_BUSY: MulDivStall = 1'b1;
            default: MulDivStall = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 5'd0;
            r_acc      <= 64'd0;
            r_opnd     <= 32'd0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_div_zero <= 1'b0;
        end else begin
            // Only true for one start cycle, so this is a one-cycle pulse
            // landing in the DONE cycle.
            r_div_zero <= w_div_zero;
            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_div_zero) begin
                        r_cnt    <= 5'd0;
                        r_is_div <= w_is_div_op;
                        r_neg_lo <= w_signed_op && (OperandA[31] ^ OperandB[31]);
                        r_neg_hi <= w_signed_op && OperandA[31];
                        if (w_is_div_op) begin
                            r_acc  <= {32'd0, w_abs_a};
                            r_opnd <= w_abs_b;
                        end else begin
                            r_acc  <= {32'd0, w_abs_b};
                            r_opnd <= w_abs_a;
                        end
                    end
                end
                ST_BUSY: begin
                    // An abort leaves HI/LO untouched; the partial state is
                    // simply abandoned and re-initialised on the next start.
                    if (!Abort) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign HI        = r_hi;
    assign LO        = r_lo;
    assign DivByZero = r_div_zero;
    assign MfSel     = w_mfhi || w_mflo;
    assign MfResult  = w_mfhi ? r_hi : (w_mflo ? r_lo : 32'd0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        abort;
  logic        stall;
  logic        mf_sel;
  logic [31:0] mf_res;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  ex_muldiv_unit dut (
    .clk         (clk),
    .rst         (rst_n),
    .ID_EX_ALUOp (aluop),
    .ID_EX_Funct (funct),
    .OperandA    (op_a),
    .OperandB    (op_b),
    .Abort       (abort),
    .MulDivStall (stall),
    .MfSel       (mf_sel),
    .MfResult    (mf_res),
    .DivByZero   (dbz),
    .HI          (hi),
    .LO          (lo),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int chk_cnt = 0;
  int pass_cnt = 0;
  int stall_cnt = 0;
  int dbz_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic is_md(input logic [1:0] ao, input logic [5:0] fn);
    return (ao == 2'b10) && (fn == 6'h18 || fn == 6'h19 || fn == 6'h1A || fn == 6'h1B);
  endfunction

  function automatic logic [63:0] ref_result(input logic [5:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (fn)
      6'h18: res = sa * sb;
      6'h19: res = ua * ub;
      6'h1A: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      6'h1B: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: an operation occupies a fixed number of cycles, then
  // the precomputed result lands in HI/LO for one done cycle.
  // ---------------------------------------------------------------------------
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          m_dbz = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;

  always @(posedge clk or negedge rst_n) begin
    logic start_now;
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      exp_q.delete();
    end else begin
      start_now = (m_left == 0) && !m_done && is_md(aluop, funct) && !abort;
      m_dbz = 1'b0;
      if (m_left > 0) begin
        if (abort) begin
          m_left = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            {m_hi, m_lo} = m_pend;
            m_done = 1'b1;
            exp_q.push_back(m_pend);
          end
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (start_now) begin
        if ((funct == 6'h1A || funct == 6'h1B) && op_b == 32'd0) begin
          m_done = 1'b1;
          m_dbz  = 1'b1;
        end else begin
          m_pend = ref_result(funct, op_a, op_b);
          m_left = 32;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process (every cycle, on the falling edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic exp_stall;
    logic exp_mfsel;
    logic [31:0] exp_mfres;
    logic [63:0] e;
    exp_stall = (m_left > 0) ||
                (rst_n && !m_done && is_md(aluop, funct) && !abort);
    exp_mfsel = (aluop == 2'b10) && (funct == 6'h10 || funct == 6'h12);
    exp_mfres = !exp_mfsel ? 32'd0 : (funct == 6'h10 ? m_hi : m_lo);
    check("stall", {63'd0, stall}, {63'd0, exp_stall});
    check("div_by_zero", {63'd0, dbz}, {63'd0, m_dbz});
    check("hi", {32'd0, hi}, {32'd0, m_hi});
    check("lo", {32'd0, lo}, {32'd0, m_lo});
    check("mf_sel", {63'd0, mf_sel}, {63'd0, exp_mfsel});
    check("mf_result", {32'd0, mf_res}, {32'd0, exp_mfres});
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard_hilo", {hi, lo}, e);
    end
    if (stall) stall_cnt++;
    if (dbz) dbz_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [1:0] ao, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b);
    aluop = ao;
    funct = fn;
    op_a  = a;
    op_b  = b;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // abort_k: -1 none, -2 abort in the start cycle, k>=0 abort at busy counter k
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int abort_k);
    drive(2'b10, fn, a, b);
    abort = 1'b0;
    if (!is_md(2'b10, fn)) begin
      step(1);
    end else if (abort_k == -2) begin
      abort = 1'b1;
      step(1);
      abort = 1'b0;
    end else if ((fn == 6'h1A || fn == 6'h1B) && b == 32'd0) begin
      step(2);
    end else if (abort_k >= 0) begin
      step(1 + abort_k);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
    end else begin
      step(34);
    end
    drive(2'b00, 6'h00, 32'd0, 32'd0);
    step(1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [5:0] fn_tab [6];

  initial begin
    fn_tab[0] = 6'h18; fn_tab[1] = 6'h19; fn_tab[2] = 6'h1A;
    fn_tab[3] = 6'h1B; fn_tab[4] = 6'h10; fn_tab[5] = 6'h12;
    abort = 1'b0;
    drive(2'b00, 6'h00, 32'd0, 32'd0);
    step(3);
    check("reset_stall", {63'd0, stall}, 64'd0);
    check("reset_dbz", {63'd0, dbz}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_state", {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;

    // Pin the reference model with hand-computed values
    check("ref_mult", ref_result(6'h18, 32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
    check("ref_multu", ref_result(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("ref_div", ref_result(6'h1A, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("ref_div_ovf", ref_result(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("ref_divu", ref_result(6'h1B, 32'd9, 32'd4), 64'h0000_0001_0000_0002);

    // MULT 7 * -3
    stall_cnt = 0;
    dbz_cnt = 0;
    run_op(6'h18, 32'd7, 32'hFFFF_FFFD, -1);
    check("mult_stall_cycles", 64'(stall_cnt), 64'd33);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_no_dbz", 64'(dbz_cnt), 64'd0);

    // MULTU max * max, then MFHI
    run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    drive(2'b10, 6'h10, 32'd0, 32'd0);
    #2;
    check("mfhi_sel", {63'd0, mf_sel}, 64'd1);
    check("mfhi_result", {32'd0, mf_res}, 64'h0000_0000_FFFF_FFFE);
    check("mfhi_no_stall", {63'd0, stall}, 64'd0);
    step(1);
    drive(2'b00, 6'h00, 32'd0, 32'd0);
    step(1);

    // Signed divides
    run_op(6'h1A, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // Divide by zero keeps HI/LO
    run_op(6'h1B, 32'h0000_2211, 32'h0000_0100, -1);
    check("divu_setup_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    stall_cnt = 0;
    dbz_cnt = 0;
    run_op(6'h1B, 32'd100, 32'd0, -1);
    check("div0_stall_cycles", 64'(stall_cnt), 64'd1);
    check("div0_pulses", 64'(dbz_cnt), 64'd1);
    check("div0_hilo", {hi, lo}, 64'h0000_0011_0000_0022);

    // Abort at busy counter 10
    stall_cnt = 0;
    run_op(6'h18, 32'd5, 32'd5, 10);
    check("abort_stall_cycles", 64'(stall_cnt), 64'd12);
    check("abort_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    check("abort_state", {62'd0, dbg_state}, 64'd0);
    run_op(6'h1B, 32'd9, 32'd4, -1);
    check("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0002);

    // Abort together with start
    drive(2'b10, 6'h18, 32'd3, 32'd3);
    abort = 1'b1;
    #2;
    check("abort_start_stall", {63'd0, stall}, 64'd0);
    step(1);
    check("abort_start_state", {62'd0, dbg_state}, 64'd0);
    drive(2'b00, 6'h00, 32'd0, 32'd0);
    abort = 1'b0;
    step(1);

    // Reset in the middle of an operation
    drive(2'b10, 6'h18, 32'h0000_1234, 32'h0000_5678);
    step(21);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_stall", {63'd0, stall}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_dbz", {63'd0, dbz}, 64'd0);
    check("midrst_state", {62'd0, dbg_state}, 64'd0);
    drive(2'b00, 6'h00, 32'd0, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      int          ak;
      int          r;
      fn = fn_tab[$urandom_range(0, 5)];
      a  = pick_operand();
      b  = pick_operand();
      if ((fn == 6'h1A || fn == 6'h1B) && $urandom_range(0, 5) == 0) b = 32'd0;
      r = int'($urandom_range(0, 9));
      if (r == 0) ak = -2;
      else if (r < 3) ak = int'($urandom_range(0, 31));
      else ak = -1;
      if ($urandom_range(0, 7) == 0) begin
        drive(2'b01, 6'h18, a, b);
        step(1);
      end
      run_op(fn, a, b, ak);
    end

    step(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

endmodule
